// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path.
// Sequencer states and byte width.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    LOAD = 5'b00010,
    REQ  = 5'b00100,
    SEND = 5'b01000,
    GAP  = 5'b10000
  } tx_fifo_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bus bundle for uart_tx_fifo: write side,
// status flags and the uart_tx launch handshake.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
);
  import uart_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;

  logic                   wr_en;
  logic [UART_BYTE_W-1:0] wr_data;
  logic                   full;
  logic                   empty;
  logic [LW-1:0]          level;
  logic                   overflow;
  logic                   tx_err;
  logic                   busy;
  logic                   data_ready;
  logic [UART_BYTE_W-1:0] byte_trans;
  logic                   trans_active;
  logic                   done_sig;

  modport master (
    output wr_en, wr_data,
    output trans_active, done_sig,
    input  full, empty, level,
    input  overflow, tx_err, busy,
    input  data_ready, byte_trans
  );

  modport slave (
    input  wr_en, wr_data,
    input  trans_active, done_sig,
    output full, empty, level,
    output overflow, tx_err, busy,
    output data_ready, byte_trans
  );

endinterface

// File: rtl/sync_fifo.sv
// Circular byte store with extra-bit pointers.
// Sticky overflow on push while full.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push;
  logic             pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointer advance and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)         wr_ptr   <= wr_ptr + 1'b1;
      if (pop)          rd_ptr   <= rd_ptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue that launches frames into uart_tx
// one at a time with an acknowledge timeout.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);

  localparam int TW = $clog2(ACK_TIMEOUT) + 1;

  tx_fifo_state_t         state, state_n;
  logic [TW-1:0]          tmo, tmo_n;
  logic                   dr_n;
  logic                   err_n;
  logic [UART_BYTE_W-1:0] bt_n;
  logic [UART_BYTE_W-1:0] rd_data;
  logic                   pop;
  logic                   can_go;
  logic                   tmo_hit;
  logic                   fifo_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_BYTE_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_data  (bus.wr_data),
    .rd_en    (pop),
    .rd_data  (rd_data),
    .full     (bus.full),
    .empty    (fifo_empty),
    .level    (bus.level),
    .overflow (bus.overflow)
  );

  assign bus.empty = fifo_empty;
  assign bus.busy  = (state != IDLE);
  assign can_go    = !fifo_empty && !bus.trans_active;
  assign tmo_hit   = (tmo == TW'(ACK_TIMEOUT - 1));

  // Next-state and register updates for the launch sequence.
  always_comb begin
    state_n = state;
    tmo_n   = tmo;
    dr_n    = bus.data_ready;
    bt_n    = bus.byte_trans;
    err_n   = bus.tx_err;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (can_go) state_n = LOAD;
      end
      LOAD: begin
        pop     = 1'b1;
        bt_n    = rd_data;
        dr_n    = 1'b1;
        tmo_n   = '0;
        state_n = REQ;
      end
      REQ: begin
        tmo_n = tmo + 1'b1;
        if (bus.trans_active) begin
          dr_n    = 1'b0;
          state_n = SEND;
        end else if (tmo_hit) begin
          dr_n    = 1'b0;
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      SEND: begin
        if (bus.done_sig || !bus.trans_active)
          state_n = GAP;
      end
      GAP: begin
        state_n = can_go ? LOAD : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, handshake outputs and timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      tmo            <= '0;
      bus.data_ready <= 1'b0;
      bus.byte_trans <= '0;
      bus.tx_err     <= 1'b0;
    end else begin
      state          <= state_n;
      tmo            <= tmo_n;
      bus.data_ready <= dr_n;
      bus.byte_trans <= bt_n;
      bus.tx_err     <= err_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a
// behavioural uart_tx at 4 clks per bit.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic model_en = 1'b1;
  logic hold_active = 1'b0;

  int total = 0;
  int passed = 0;
  int fails = 0;

  logic [7:0] rx_q [$];

  logic m_busy;
  int   m_cnt;

  uart_tx_fifo_if #(.DEPTH(16)) bus ();

  uart_tx_fifo #(
    .DEPTH       (16),
    .ACK_TIMEOUT (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.trans_active = m_busy | hold_active;
  assign bus.done_sig     = m_busy && (m_cnt == 39);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (model_en && bus.data_ready) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        rx_q.push_back(bus.byte_trans);
      end
    end else if (m_cnt == 39) begin
      m_busy <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("rx_wait", 32'(rx_q.size()), 32'(n));
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!bus.done_sig && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_wait", 32'(bus.done_sig), 32'd1);
  endtask

  initial begin
    int cnt;
    int bad;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_dr", 32'(bus.data_ready), 32'd0);
    chk("rst_bt", 32'(bus.byte_trans), 32'h00);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_err", 32'(bus.tx_err), 32'd0);

    // 1: two bytes back to back
    push(8'h48);
    push(8'h49);
    chk("t1_dr_early", 32'(bus.data_ready), 32'd0);
    @(negedge clk);
    chk("t1_dr_rise", 32'(bus.data_ready), 32'd1);
    chk("t1_bt", 32'(bus.byte_trans), 32'h48);
    wait_done(200);
    @(negedge clk);
    wait_done(200);
    repeat (2) @(negedge clk);
    chk("t1_empty", 32'(bus.empty), 32'd1);
    chk("t1_busy", 32'(bus.busy), 32'd0);
    chk("t1_rxn", 32'(rx_q.size()), 32'd2);
    chk("t1_rx0", 32'(rx_q[0]), 32'h48);
    chk("t1_rx1", 32'(rx_q[1]), 32'h49);

    // 2: overflow while link held busy
    do_reset();
    hold_active = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(8'hA0 + i));
    chk("t2_full", 32'(bus.full), 32'd1);
    chk("t2_lvl16", 32'(bus.level), 32'd16);
    chk("t2_ovf0", 32'(bus.overflow), 32'd0);
    push(8'hB0);
    chk("t2_ovf1", 32'(bus.overflow), 32'd1);
    chk("t2_lvl", 32'(bus.level), 32'd16);
    hold_active = 1'b0;
    wait_rx(16, 1500);
    repeat (100) @(negedge clk);
    chk("t2_rxn", 32'(rx_q.size()), 32'd16);
    chk("t2_first", 32'(rx_q[0]), 32'hA0);
    chk("t2_last", 32'(rx_q[15]), 32'hAF);
    chk("t2_empty", 32'(bus.empty), 32'd1);

    // 3: push coincides with LOAD pop
    do_reset();
    push(8'h11);
    @(negedge clk);
    chk("t3_lvl_pre", 32'(bus.level), 32'd1);
    push(8'h22);
    chk("t3_lvl", 32'(bus.level), 32'd1);
    chk("t3_dr", 32'(bus.data_ready), 32'd1);
    chk("t3_bt", 32'(bus.byte_trans), 32'h11);
    wait_rx(2, 300);
    chk("t3_rx0", 32'(rx_q[0]), 32'h11);
    chk("t3_rx1", 32'(rx_q[1]), 32'h22);

    // 4: no acknowledge, timeout abort
    do_reset();
    model_en = 1'b0;
    push(8'h5A);
    cnt = 0;
    while (!bus.data_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("t4_dr_seen", 32'(bus.data_ready), 32'd1);
    cnt = 0;
    while (bus.data_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("t4_dr_len", 32'(cnt), 32'd8);
    chk("t4_err", 32'(bus.tx_err), 32'd1);
    chk("t4_busy", 32'(bus.busy), 32'd0);
    chk("t4_empty", 32'(bus.empty), 32'd1);
    model_en = 1'b1;

    // 5: reset in the middle of the third frame
    do_reset();
    for (int i = 0; i < 5; i++) push(8'(8'h31 + i));
    wait_rx(3, 600);
    repeat (5) @(negedge clk);
    chk("t5_lvl_pre", 32'(bus.level), 32'd2);
    chk("t5_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_dr", 32'(bus.data_ready), 32'd0);
    chk("t5_lvl", 32'(bus.level), 32'd0);
    chk("t5_empty", 32'(bus.empty), 32'd1);
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_flags", 32'({bus.full, bus.overflow, bus.tx_err}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("t5_rxn", 32'(rx_q.size()), 32'd3);
    chk("t5_idle", 32'(bus.busy), 32'd0);

    // 6: pointer wrap over 40 bytes
    do_reset();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) push(8'(b * 10 + i));
      wait_rx((b + 1) * 10, 800);
    end
    bad = 0;
    for (int i = 0; i < 40; i++)
      if (rx_q[i] !== 8'(i)) bad++;
    chk("t6_rxn", 32'(rx_q.size()), 32'd40);
    chk("t6_order", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
